// File: rtl/parity_if.sv
// parity_if: groups the parity generator/checker data bus.
//   master : drives A/B/C/P, in_valid, clr_cnt; observes results
//   slave  : the parity_gen_det side
//   A,B,C        data bits 2..0
//   P            received parity bit
//   in_valid     qualifies the sample for the error counters
//   clr_cnt      synchronous clear of both error counters
//   Peven/Podd   generated parity for {A,B,C}
//   Check_even/Check_odd  parity violation flags for {A,B,C,P}
//   out_valid    in_valid aligned with the outputs
//   err_even_cnt/err_odd_cnt  saturating error counters
interface parity_if #(
    parameter int CNT_W = 8
);
    logic             A, B, C, P;
    logic             in_valid, clr_cnt;
    logic             Peven, Podd, Check_even, Check_odd, out_valid;
    logic [CNT_W-1:0] err_even_cnt, err_odd_cnt;

    modport master (
        output A, B, C, P, in_valid, clr_cnt,
        input  Peven, Podd, Check_even, Check_odd, out_valid, err_even_cnt, err_odd_cnt
    );
    modport slave (
        input  A, B, C, P, in_valid, clr_cnt,
        output Peven, Podd, Check_even, Check_odd, out_valid, err_even_cnt, err_odd_cnt
    );
endinterface

// File: rtl/parity_gen_det.sv
// parity_gen_det: 3-bit even/odd parity generator plus 4-bit parity checker
// with optional output registering and saturating error counters.
//   clk    single clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    parity_if.slave (data in, parity/check/valid/counters out)
// REG_OUT=1 registers all outputs (1-cycle latency); REG_OUT=0 leaves the
// parity/check outputs combinational with out_valid = in_valid.
// The error counters are always registered and sample the current inputs.
module parity_gen_det #(
    parameter int REG_OUT = 1,
    parameter int CNT_W   = 8
) (
    input  logic     clk,
    input  logic     rst_n,
    parity_if.slave  bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic pe_c;   // even-parity bit of {A,B,C}
    logic ce_c;   // even-parity violation of {A,B,C,P}

    assign pe_c = bus.A ^ bus.B ^ bus.C;
    assign ce_c = pe_c ^ bus.P;

    generate
        if (REG_OUT != 0) begin : g_reg
            logic pe_q, po_q, ce_q, co_q, vld_q;

            // Outputs update every cycle regardless of in_valid; only the
            // counters are qualified.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    pe_q  <= 1'b0;
                    po_q  <= 1'b0;
                    ce_q  <= 1'b0;
                    co_q  <= 1'b0;
                    vld_q <= 1'b0;
                end else begin
                    pe_q  <= pe_c;
                    po_q  <= ~pe_c;
                    ce_q  <= ce_c;
                    co_q  <= ~ce_c;
                    vld_q <= bus.in_valid;
                end
            end

            assign bus.Peven      = pe_q;
            assign bus.Podd       = po_q;
            assign bus.Check_even = ce_q;
            assign bus.Check_odd  = co_q;
            assign bus.out_valid  = vld_q;
        end else begin : g_comb
            assign bus.Peven      = pe_c;
            assign bus.Podd       = ~pe_c;
            assign bus.Check_even = ce_c;
            assign bus.Check_odd  = ~ce_c;
            assign bus.out_valid  = bus.in_valid;
        end
    endgenerate

    logic [CNT_W-1:0] err_even_q, err_odd_q;

    // Clear beats increment; increments stop at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_even_q <= '0;
            err_odd_q  <= '0;
        end else if (bus.clr_cnt) begin
            err_even_q <= '0;
            err_odd_q  <= '0;
        end else if (bus.in_valid) begin
            if (ce_c && err_even_q != CNT_MAX)
                err_even_q <= err_even_q + CNT_W'(1);
            if (!ce_c && err_odd_q != CNT_MAX)
                err_odd_q <= err_odd_q + CNT_W'(1);
        end
    end

    assign bus.err_even_cnt = err_even_q;
    assign bus.err_odd_cnt  = err_odd_q;
endmodule

// File: tb/tb_parity_gen_det.sv
module tb_parity_gen_det;
    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    parity_if #(.CNT_W(2)) if1 ();
    parity_if #(.CNT_W(2)) if0 ();

    parity_gen_det #(.REG_OUT(1), .CNT_W(2)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    parity_gen_det #(.REG_OUT(0), .CNT_W(2)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));

    // {A,B,C,P, Peven,Podd,Check_even,Check_odd}
    logic [7:0] tbl [8] = '{
        8'b0000_0101, 8'b0001_0110,
        8'b0110_0101, 8'b0111_0110,
        8'b1010_0101, 8'b1011_0110,
        8'b1111_1001, 8'b1110_1010
    };

    task automatic drive(input logic a, b, c, p, v, clr);
        if1.A = a; if1.B = b; if1.C = c; if1.P = p; if1.in_valid = v; if1.clr_cnt = clr;
        if0.A = a; if0.B = b; if0.C = c; if0.P = p; if0.in_valid = v; if0.clr_cnt = clr;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        #12;
        total++;
        if ({if1.Peven, if1.Podd, if1.Check_even, if1.Check_odd, if1.out_valid} !== 5'b00000) begin
            bad++;
            $display("FAIL reset_outs1: got %b want 00000",
                     {if1.Peven, if1.Podd, if1.Check_even, if1.Check_odd, if1.out_valid});
        end
        total++;
        if ({if1.err_even_cnt, if1.err_odd_cnt, if0.err_even_cnt, if0.err_odd_cnt} !== 8'h00) begin
            bad++;
            $display("FAIL reset_cnts: got %h want 00",
                     {if1.err_even_cnt, if1.err_odd_cnt, if0.err_even_cnt, if0.err_odd_cnt});
        end
        // combinational variant follows its inputs even in reset
        total++;
        if ({if0.Peven, if0.Podd, if0.Check_even, if0.Check_odd, if0.out_valid} !== 5'b01010) begin
            bad++;
            $display("FAIL reset_comb0: got %b want 01010",
                     {if0.Peven, if0.Podd, if0.Check_even, if0.Check_odd, if0.out_valid});
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_table();
        logic [3:0] prev;
        drive(0, 0, 0, 0, 0, 0);
        step();
        prev = 4'b0101;
        for (int i = 0; i < 8; i++) begin
            drive(tbl[i][7], tbl[i][6], tbl[i][5], tbl[i][4], 0, 0);
            #1;
            total++;
            if ({if0.Peven, if0.Podd, if0.Check_even, if0.Check_odd} !== tbl[i][3:0]) begin
                bad++;
                $display("FAIL table%0d comb: got %b want %b", i,
                         {if0.Peven, if0.Podd, if0.Check_even, if0.Check_odd}, tbl[i][3:0]);
            end
            // registered outputs must not have moved yet
            total++;
            if ({if1.Peven, if1.Podd, if1.Check_even, if1.Check_odd} !== prev) begin
                bad++;
                $display("FAIL table%0d early: got %b want %b", i,
                         {if1.Peven, if1.Podd, if1.Check_even, if1.Check_odd}, prev);
            end
            step();
            total++;
            if ({if1.Peven, if1.Podd, if1.Check_even, if1.Check_odd} !== tbl[i][3:0]) begin
                bad++;
                $display("FAIL table%0d reg: got %b want %b", i,
                         {if1.Peven, if1.Podd, if1.Check_even, if1.Check_odd}, tbl[i][3:0]);
            end
            prev = tbl[i][3:0];
        end
    endtask

    task automatic test_all16();
        logic [3:0] v;
        logic       pe, ce;
        for (int i = 0; i < 16; i++) begin
            v  = 4'(i);
            pe = v[3] ^ v[2] ^ v[1];
            ce = pe ^ v[0];
            drive(v[3], v[2], v[1], v[0], 0, 0);
            #1;
            total++;
            if ({if0.Peven, if0.Podd, if0.Check_even, if0.Check_odd} !== {pe, ~pe, ce, ~ce}) begin
                bad++;
                $display("FAIL all16_%0d comb: got %b want %b", i,
                         {if0.Peven, if0.Podd, if0.Check_even, if0.Check_odd}, {pe, ~pe, ce, ~ce});
            end
            step();
            total++;
            if ({if1.Peven, if1.Podd, if1.Check_even, if1.Check_odd} !== {pe, ~pe, ce, ~ce}) begin
                bad++;
                $display("FAIL all16_%0d reg: got %b want %b", i,
                         {if1.Peven, if1.Podd, if1.Check_even, if1.Check_odd}, {pe, ~pe, ce, ~ce});
            end
        end
        // in_valid was low throughout: counters untouched
        total++;
        if ({if1.err_even_cnt, if1.err_odd_cnt} !== 4'h0) begin
            bad++;
            $display("FAIL all16 cnt hold: got %h want 0", {if1.err_even_cnt, if1.err_odd_cnt});
        end
    endtask

    task automatic test_counters();
        logic [1:0] exp_e;
        drive(0, 0, 0, 1, 1, 0);  // Check_even=1
        for (int k = 0; k < 5; k++) begin
            step();
            exp_e = (k >= 2) ? 2'd3 : 2'(k + 1);
            total++;
            if ({if1.err_even_cnt, if1.err_odd_cnt, if0.err_even_cnt, if0.err_odd_cnt} !== {exp_e, 2'd0, exp_e, 2'd0}) begin
                bad++;
                $display("FAIL sat%0d: got %b want %b", k,
                         {if1.err_even_cnt, if1.err_odd_cnt, if0.err_even_cnt, if0.err_odd_cnt},
                         {exp_e, 2'd0, exp_e, 2'd0});
            end
        end
        total++;
        if ({if1.out_valid, if0.out_valid} !== 2'b11) begin
            bad++;
            $display("FAIL out_valid hi: got %b want 11", {if1.out_valid, if0.out_valid});
        end
        drive(0, 0, 0, 0, 0, 0);  // Check_odd=1 but not valid
        #1;
        total++;
        if ({if1.out_valid, if0.out_valid} !== 2'b10) begin
            bad++;
            $display("FAIL out_valid lag: got %b want 10", {if1.out_valid, if0.out_valid});
        end
        step();
        step();
        total++;
        if ({if1.err_even_cnt, if1.err_odd_cnt, if1.out_valid} !== 5'b11_00_0) begin
            bad++;
            $display("FAIL hold: got %b want 11000", {if1.err_even_cnt, if1.err_odd_cnt, if1.out_valid});
        end
        drive(0, 0, 0, 0, 1, 0);
        step();
        total++;
        if ({if1.err_even_cnt, if1.err_odd_cnt, if0.err_even_cnt, if0.err_odd_cnt} !== 8'b11_01_11_01) begin
            bad++;
            $display("FAIL odd inc: got %b want 11011101",
                     {if1.err_even_cnt, if1.err_odd_cnt, if0.err_even_cnt, if0.err_odd_cnt});
        end
        drive(0, 0, 0, 1, 1, 1);  // clear with an error present
        step();
        total++;
        if ({if1.err_even_cnt, if1.err_odd_cnt, if0.err_even_cnt, if0.err_odd_cnt} !== 8'h00) begin
            bad++;
            $display("FAIL clr prio: got %b want 00000000",
                     {if1.err_even_cnt, if1.err_odd_cnt, if0.err_even_cnt, if0.err_odd_cnt});
        end
    endtask

    task automatic test_async_reset();
        drive(1, 0, 0, 0, 1, 0);  // Peven=1, Check_even=1
        step();
        step();
        total++;
        if ({if1.Peven, if1.Podd, if1.Check_even, if1.Check_odd, if1.err_even_cnt} !== 6'b1010_10) begin
            bad++;
            $display("FAIL pre_rst: got %b want 101010",
                     {if1.Peven, if1.Podd, if1.Check_even, if1.Check_odd, if1.err_even_cnt});
        end
        #3;
        rst_n = 1'b0;  // between edges
        #1;
        total++;
        if ({if1.Peven, if1.Podd, if1.Check_even, if1.Check_odd, if1.out_valid,
             if1.err_even_cnt, if0.err_even_cnt} !== 9'b0) begin
            bad++;
            $display("FAIL async_rst: got %b want 000000000",
                     {if1.Peven, if1.Podd, if1.Check_even, if1.Check_odd, if1.out_valid,
                      if1.err_even_cnt, if0.err_even_cnt});
        end
        step();
        total++;
        if ({if1.Peven, if1.err_even_cnt} !== 3'b0) begin
            bad++;
            $display("FAIL rst_hold: got %b want 000", {if1.Peven, if1.err_even_cnt});
        end
        rst_n = 1'b1;
        step();
        total++;
        if ({if1.Peven, if1.Podd, if1.Check_even, if1.Check_odd, if1.out_valid,
             if1.err_even_cnt, if0.err_even_cnt} !== 9'b10101_01_01) begin
            bad++;
            $display("FAIL post_rst: got %b want 101010101",
                     {if1.Peven, if1.Podd, if1.Check_even, if1.Check_odd, if1.out_valid,
                      if1.err_even_cnt, if0.err_even_cnt});
        end
        drive(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        test_reset();
        test_table();
        test_all16();
        test_counters();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
